// File: rtl/time_setter_pkg.sv
// Shared types, field indices, reset date and calendar helpers for the time setter.
package time_pkg;

    localparam logic [2:0] FLD_YEAR  = 3'd0;
    localparam logic [2:0] FLD_MONTH = 3'd1;
    localparam logic [2:0] FLD_DAY   = 3'd2;
    localparam logic [2:0] FLD_HOUR  = 3'd3;
    localparam logic [2:0] FLD_MIN   = 3'd4;
    localparam logic [2:0] FLD_SEC   = 3'd5;
    localparam logic [2:0] FLD_NONE  = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EDIT     = 2'd1,
        ST_WAIT_DOW = 2'd2
    } state_t;

    // Power-on date: Tuesday 2023-05-09 00:00:00
    localparam logic [14:0] RST_YEAR  = 15'd2023;
    localparam logic [3:0]  RST_MONTH = 4'd5;
    localparam logic [4:0]  RST_DAY   = 5'd9;
    localparam logic [5:0]  RST_HOUR  = 6'd0;
    localparam logic [5:0]  RST_MIN   = 6'd0;
    localparam logic [5:0]  RST_SEC   = 6'd0;
    localparam logic [3:0]  RST_WEEK  = 4'd2;

    function automatic logic is_leap(input logic [14:0] year);
        return ((year % 15'd4) == 15'd0) &&
               (((year % 15'd100) != 15'd0) || ((year % 15'd400) == 15'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [14:0] year);
        logic [4:0] dim;
        case (month)
            4'd2:                      dim = is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/time_setter_if.sv
// Button, live-time and set-side signals of the time setter.
interface time_setter_if;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_up;
    logic        btn_down;
    logic [14:0] cur_year;
    logic [3:0]  cur_month;
    logic [4:0]  cur_day;
    logic [5:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;
    logic [14:0] year_d;
    logic [3:0]  month_d;
    logic [4:0]  day_d;
    logic [5:0]  hour_d;
    logic [5:0]  min_d;
    logic [5:0]  sec_d;
    logic [3:0]  week_s;
    logic [3:0]  mode;
    logic [2:0]  field_sel;

    modport master (
        output btn_mode, btn_next, btn_up, btn_down,
        output cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        input  year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, mode, field_sel
    );

    modport slave (
        input  btn_mode, btn_next, btn_up, btn_down,
        input  cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        output year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, mode, field_sel
    );
endinterface

// File: rtl/time_setter_dow_calc.sv
// Two-stage Zeller weekday calculator: done pulses two cycles after start;
// a start while busy supersedes the older result.
module dow_calc
    import time_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [14:0] year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    output logic [3:0]  week,
    output logic        done
);

    logic [16:0] adj_m;
    logic [16:0] adj_y;
    logic [16:0] s1_q;
    logic [16:0] s1_t;
    logic [16:0] s1_k;
    logic [16:0] s1_j;
    logic        s1_v;
    logic [16:0] sum;
    logic [16:0] h;
    logic [16:0] wk;

    // January and February count as months 13/14 of the previous year
    always_comb begin
        if (month <= 4'd2) begin
            adj_m = {13'd0, month} + 17'd12;
            adj_y = {2'd0, year} - 17'd1;
        end else begin
            adj_m = {13'd0, month};
            adj_y = {2'd0, year};
        end
    end

    // Stage 1: register day, month term and century split
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_q <= '0;
            s1_t <= '0;
            s1_k <= '0;
            s1_j <= '0;
        end else begin
            s1_v <= start;
            if (start) begin
                s1_q <= {12'd0, day};
                s1_t <= (17'd13 * (adj_m + 17'd1)) / 17'd5;
                s1_k <= adj_y % 17'd100;
                s1_j <= adj_y / 17'd100;
            end
        end
    end

    // h = 0 is Saturday; remap so that 1 = Monday .. 7 = Sunday
    always_comb begin
        sum = s1_q + s1_t + s1_k + (s1_k / 17'd4) + (s1_j / 17'd4) + (17'd5 * s1_j);
        h   = sum % 17'd7;
        wk  = ((h + 17'd5) % 17'd7) + 17'd1;
    end

    // Stage 2: reduce mod 7; a new start in the same cycle drops this result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            week <= RST_WEEK;
        end else begin
            done <= s1_v & ~start;
            if (s1_v & ~start)
                week <= wk[3:0];
        end
    end

endmodule

// File: rtl/time_setter.sv
// Time/date editor driving the set side of the time keeper.
// Optional build macro: TIME_SETTER_SEC_ZERO_EN (up/down on seconds clears them).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | fields shadow live time, mode = RUN_MODE
// ST_EDIT     | mode = 0, buttons step the selected field
// ST_WAIT_DOW | mode = 0, waiting for the final weekday before releasing
module time_setter
    import time_pkg::*;
#(
    parameter logic [3:0]  RUN_MODE = 4'd1,
    parameter int unsigned YEAR_MIN = 1583,
    parameter int unsigned YEAR_MAX = 9999
) (
    input  logic          clk,
    input  logic          rst,
    time_setter_if.slave  bus
);

    localparam logic [14:0] Y_MIN = YEAR_MIN[14:0];
    localparam logic [14:0] Y_MAX = YEAR_MAX[14:0];

    state_t      state;
    logic [14:0] year_q;
    logic [3:0]  month_q;
    logic [4:0]  day_q;
    logic [5:0]  hour_q;
    logic [5:0]  min_q;
    logic [5:0]  sec_q;
    logic [3:0]  week_q;
    logic [3:0]  mode_q;
    logic [2:0]  sel_q;
    logic        dow_req_q;

    logic [14:0] nxt_year;
    logic [3:0]  nxt_month;
    logic [4:0]  nxt_day;
    logic [5:0]  nxt_hour;
    logic [5:0]  nxt_min;
    logic [5:0]  nxt_sec;
    logic [4:0]  dim_cur;
    logic [4:0]  dim_new;
    logic        ymd_touch;
    logic        step_up;
    logic        dow_start;
    logic [3:0]  dow_week;
    logic        dow_done;

    assign step_up   = bus.btn_up;
    assign dim_cur   = days_in_month(month_q, year_q);
    // Exit start uses the current fields: btn_mode blocks any edit in that cycle
    assign dow_start = dow_req_q | ((state == ST_EDIT) & bus.btn_mode);

    // Candidate value of the selected field after one up/down step, with day clamp
    always_comb begin
        nxt_year  = year_q;
        nxt_month = month_q;
        nxt_day   = day_q;
        nxt_hour  = hour_q;
        nxt_min   = min_q;
        nxt_sec   = sec_q;
        dim_new   = dim_cur;
        ymd_touch = 1'b0;
        case (sel_q)
            FLD_YEAR: begin
                if (step_up) nxt_year = (year_q >= Y_MAX) ? Y_MIN : year_q + 15'd1;
                else         nxt_year = (year_q <= Y_MIN) ? Y_MAX : year_q - 15'd1;
                dim_new = days_in_month(month_q, nxt_year);
                if (day_q > dim_new) nxt_day = dim_new;
                ymd_touch = 1'b1;
            end
            FLD_MONTH: begin
                if (step_up) nxt_month = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                else         nxt_month = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
                dim_new = days_in_month(nxt_month, year_q);
                if (day_q > dim_new) nxt_day = dim_new;
                ymd_touch = 1'b1;
            end
            FLD_DAY: begin
                if (step_up) nxt_day = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
                else         nxt_day = (day_q <= 5'd1) ? dim_cur : day_q - 5'd1;
                ymd_touch = 1'b1;
            end
            FLD_HOUR: begin
                if (step_up) nxt_hour = (hour_q >= 6'd23) ? 6'd0 : hour_q + 6'd1;
                else         nxt_hour = (hour_q == 6'd0) ? 6'd23 : hour_q - 6'd1;
            end
            FLD_MIN: begin
                if (step_up) nxt_min = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
                else         nxt_min = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
            end
            FLD_SEC: begin
`ifdef TIME_SETTER_SEC_ZERO_EN
                nxt_sec = 6'd0;
`else
                if (step_up) nxt_sec = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
                else         nxt_sec = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
`endif
            end
            default: ;
        endcase
    end

    // Editor FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            year_q    <= RST_YEAR;
            month_q   <= RST_MONTH;
            day_q     <= RST_DAY;
            hour_q    <= RST_HOUR;
            min_q     <= RST_MIN;
            sec_q     <= RST_SEC;
            week_q    <= RST_WEEK;
            mode_q    <= RUN_MODE;
            sel_q     <= FLD_NONE;
            dow_req_q <= 1'b0;
        end else begin
            dow_req_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    year_q  <= bus.cur_year;
                    month_q <= bus.cur_month;
                    day_q   <= bus.cur_day;
                    hour_q  <= bus.cur_hour;
                    min_q   <= bus.cur_min;
                    sec_q   <= bus.cur_sec;
                    mode_q  <= RUN_MODE;
                    sel_q   <= FLD_NONE;
                    if (bus.btn_mode) begin
                        state  <= ST_EDIT;
                        sel_q  <= FLD_YEAR;
                        mode_q <= 4'd0;
                    end
                end
                ST_EDIT: begin
                    if (dow_done)
                        week_q <= dow_week;
                    if (bus.btn_mode) begin
                        state <= ST_WAIT_DOW;
                        sel_q <= FLD_NONE;
                    end else if (bus.btn_next) begin
                        sel_q <= (sel_q >= FLD_SEC) ? FLD_YEAR : sel_q + 3'd1;
                    end else if (bus.btn_up | bus.btn_down) begin
                        year_q    <= nxt_year;
                        month_q   <= nxt_month;
                        day_q     <= nxt_day;
                        hour_q    <= nxt_hour;
                        min_q     <= nxt_min;
                        sec_q     <= nxt_sec;
                        dow_req_q <= ymd_touch;
                    end
                end
                ST_WAIT_DOW: begin
                    if (dow_done) begin
                        week_q <= dow_week;
                        state  <= ST_RUN;
                        mode_q <= RUN_MODE;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    dow_calc u_dow (
        .clk   (clk),
        .rst   (rst),
        .start (dow_start),
        .year  (year_q),
        .month (month_q),
        .day   (day_q),
        .week  (dow_week),
        .done  (dow_done)
    );

    assign bus.year_d    = year_q;
    assign bus.month_d   = month_q;
    assign bus.day_d     = day_q;
    assign bus.hour_d    = hour_q;
    assign bus.min_d     = min_q;
    assign bus.sec_d     = sec_q;
    assign bus.week_s    = week_q;
    assign bus.mode      = mode_q;
    assign bus.field_sel = sel_q;

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed corner cases plus randomized edit sessions
// against a calendar model (weekday from a day count, not Zeller).
module tb_time_setter;

    logic clk = 1'b0;
    logic rst;

    time_setter_if bus();

    time_setter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int mf[6];
    int msel;
    int mweek;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit leap(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int dim(input int m, input int y);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && leap(y)) return 29;
        return tbl[m-1];
    endfunction

    // Day number with day 1 = Monday 0001-01-01 (proleptic Gregorian)
    function automatic int weekday(input int y, input int m, input int d);
        int cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
        int n;
        n = 365 * (y - 1) + (y - 1) / 4 - (y - 1) / 100 + (y - 1) / 400 + cum[m-1] + d;
        if (m > 2 && leap(y)) n++;
        return ((n - 1) % 7) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit bm, input bit bn, input bit bu, input bit bd);
        bus.btn_mode = bm;
        bus.btn_next = bn;
        bus.btn_up   = bu;
        bus.btn_down = bd;
        tick();
        bus.btn_mode = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
    endtask

    task automatic check_fields(input string tag, input int exp_mode, input int exp_sel);
        chk({tag, ".year"},  bus.year_d,    mf[0]);
        chk({tag, ".month"}, bus.month_d,   mf[1]);
        chk({tag, ".day"},   bus.day_d,     mf[2]);
        chk({tag, ".hour"},  bus.hour_d,    mf[3]);
        chk({tag, ".min"},   bus.min_d,     mf[4]);
        chk({tag, ".sec"},   bus.sec_d,     mf[5]);
        chk({tag, ".mode"},  bus.mode,      exp_mode);
        chk({tag, ".sel"},   bus.field_sel, exp_sel);
    endtask

    task automatic model_reset();
        mf = '{2023, 5, 9, 0, 0, 0};
        mweek = 2;
        msel = 7;
    endtask

    task automatic check_reset(input string tag);
        model_reset();
        check_fields(tag, 1, 7);
        chk({tag, ".week"}, bus.week_s, 2);
    endtask

    task automatic seed(input int y, input int mo, input int d, input int h, input int mi, input int s);
        bus.cur_year  = 15'(y);
        bus.cur_month = 4'(mo);
        bus.cur_day   = 5'(d);
        bus.cur_hour  = 6'(h);
        bus.cur_min   = 6'(mi);
        bus.cur_sec   = 6'(s);
        mf = '{y, mo, d, h, mi, s};
        tick();
        check_fields("run_load", 1, 7);
        chk("run_week_hold", bus.week_s, mweek);
    endtask

    task automatic enter_edit();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        msel = 0;
        check_fields("enter", 0, 0);
    endtask

    task automatic model_step(input bit bn, input bit bu, input bit bd);
        int lo, hi;
        if (bn) begin
            msel = (msel == 5) ? 0 : msel + 1;
        end else if (bu || bd) begin
            case (msel)
                0:       begin lo = 1583; hi = 9999; end
                1:       begin lo = 1;    hi = 12;   end
                2:       begin lo = 1;    hi = dim(mf[1], mf[0]); end
                3:       begin lo = 0;    hi = 23;   end
                default: begin lo = 0;    hi = 59;   end
            endcase
            mf[msel] = mf[msel] + (bu ? 1 : -1);
            if (mf[msel] > hi) mf[msel] = lo;
            if (mf[msel] < lo) mf[msel] = hi;
`ifdef TIME_SETTER_SEC_ZERO_EN
            if (msel == 5) mf[5] = 0;
`endif
            if (msel <= 1 && mf[2] > dim(mf[1], mf[0])) mf[2] = dim(mf[1], mf[0]);
            if (msel <= 2) mweek = weekday(mf[0], mf[1], mf[2]);
        end
    endtask

    task automatic edit_press(input bit bn, input bit bu, input bit bd);
        press(1'b0, bn, bu, bd);
        model_step(bn, bu, bd);
        check_fields("edit", 0, msel);
        repeat (3) tick();
        chk("edit_week", bus.week_s, mweek);
        chk("edit_mode_hold", bus.mode, 0);
    endtask

    task automatic exit_edit(input bit bn, input bit bu, input bit bd);
        press(1'b1, bn, bu, bd);
        check_fields("exit0", 0, 7);
        tick();
        chk("exit1.mode", bus.mode, 0);
        tick();
        mweek = weekday(mf[0], mf[1], mf[2]);
        check_fields("exit2", 1, 7);
        chk("exit2.week", bus.week_s, mweek);
        msel = 7;
    endtask

    task automatic rand_seed();
        int y, mo, d;
        case ($urandom_range(0, 4))
            0:       y = 1583;
            1:       y = 9999;
            2:       y = $urandom_range(16, 99) * 100;
            default: y = $urandom_range(1583, 9999);
        endcase
        mo = $urandom_range(1, 12);
        d  = ($urandom_range(0, 1) == 0) ? dim(mo, y) : $urandom_range(1, dim(mo, y));
        seed(y, mo, d, $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.cur_year  = 15'd2023;
        bus.cur_month = 4'd5;
        bus.cur_day   = 5'd9;
        bus.cur_hour  = 6'd12;
        bus.cur_min   = 6'd0;
        bus.cur_sec   = 6'd0;
        rst = 1'b1;
        repeat (2) tick();
        check_reset("reset");
        rst = 1'b0;

        // Live time 2023-05-09 12:00:00, in and straight out of edit
        seed(2023, 5, 9, 12, 0, 0);
        enter_edit();
        exit_edit(1'b0, 1'b0, 1'b0);
        chk("anchor_week", bus.week_s, 2);

        // Leap-day clamp on year change: 2001-02-28 is a Wednesday
        seed(2000, 2, 29, 8, 30, 15);
        enter_edit();
        edit_press(1'b0, 1'b1, 1'b0);
        chk("leap_clamp.year", bus.year_d, 2001);
        chk("leap_clamp.day", bus.day_d, 28);
        chk("leap_clamp.week", bus.week_s, 3);
        exit_edit(1'b0, 1'b0, 1'b0);

        // Wrap boundaries for year, month, hour, seconds
        seed(9999, 12, 31, 23, 0, 0);
        enter_edit();
        edit_press(1'b0, 1'b1, 1'b0);
        chk("wrap.year", bus.year_d, 1583);
        edit_press(1'b1, 1'b0, 1'b0);
        edit_press(1'b0, 1'b1, 1'b0);
        chk("wrap.month", bus.month_d, 1);
        edit_press(1'b1, 1'b0, 1'b0);
        edit_press(1'b1, 1'b0, 1'b0);
        edit_press(1'b0, 1'b1, 1'b0);
        chk("wrap.hour", bus.hour_d, 0);
        edit_press(1'b1, 1'b0, 1'b0);
        edit_press(1'b1, 1'b0, 1'b0);
        edit_press(1'b0, 1'b0, 1'b1);
`ifndef TIME_SETTER_SEC_ZERO_EN
        chk("wrap.sec", bus.sec_d, 59);
`endif
        edit_press(1'b1, 1'b0, 1'b0);
        chk("wrap.sel", bus.field_sel, 0);
        exit_edit(1'b0, 1'b0, 1'b0);

        // Month change clamps day and never un-clamps
        seed(2023, 1, 31, 0, 0, 0);
        enter_edit();
        edit_press(1'b1, 1'b0, 1'b0);
        edit_press(1'b0, 1'b1, 1'b0);
        chk("mclamp.up.month", bus.month_d, 2);
        chk("mclamp.up.day", bus.day_d, 28);
        edit_press(1'b0, 1'b0, 1'b1);
        chk("mclamp.dn.month", bus.month_d, 1);
        chk("mclamp.dn.day", bus.day_d, 28);
        exit_edit(1'b0, 1'b0, 1'b0);

        // Button priority
        seed(2010, 6, 15, 10, 20, 30);
        enter_edit();
        edit_press(1'b1, 1'b1, 1'b0);
        chk("prio.sel", bus.field_sel, 1);
        chk("prio.year", bus.year_d, 2010);
        edit_press(1'b0, 1'b1, 1'b1);
        chk("prio.up_over_down", bus.month_d, 7);
        exit_edit(1'b0, 1'b1, 1'b0);
        chk("prio.exit_month", bus.month_d, 7);

        // Reset while waiting for the weekday
        seed(2024, 2, 29, 1, 2, 3);
        enter_edit();
        edit_press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wait.mode", bus.mode, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset("rst_wait");
        tick();
        tick();
        check_reset("rst_hold");
        rst = 1'b0;
        tick();
        chk("rst_after.week", bus.week_s, 2);
        chk("rst_after.mode", bus.mode, 1);

        // Randomized edit sessions
        for (int r = 0; r < 30; r++) begin
            rand_seed();
            enter_edit();
            for (int k = 0; k < 12; k++) begin
                int pick;
                pick = $urandom_range(0, 9);
                if (pick <= 2)      edit_press(1'b1, 1'b0, 1'b0);
                else if (pick <= 5) edit_press(1'b0, 1'b1, 1'b0);
                else if (pick <= 8) edit_press(1'b0, 1'b0, 1'b1);
                else edit_press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            exit_edit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
- User-facing time/date editor that drives the set-side interface of the clock's time-keeping counter: year_d, month_d, day_d, hour_d, min_d, sec_d, week_s and mode.
- While running, it shadows the live time. On a mode button press it enters edit mode and drives mode=0, so the counter loads the edited fields. The user steps through the fields with up/down buttons.
- On exit it computes the weekday, then releases mode to RUN_MODE so counting resumes from the edited values.

Parameters:
- RUN_MODE, 4'd1, value driven on mode when not editing; must be nonzero.
- YEAR_MIN, 1583, lowest settable year (Gregorian only).
- YEAR_MAX, 9999, highest settable year.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- btn_mode  in  1  one-cycle debounced pulse: enter/exit edit
- btn_next  in  1  one-cycle pulse: advance to next field
- btn_up  in  1  one-cycle pulse: increment selected field
- btn_down  in  1  one-cycle pulse: decrement selected field
- cur_year  in  15  live year from time keeper
- cur_month  in  4  live month
- cur_day  in  5  live day
- cur_hour  in  6  live hour
- cur_min  in  6  live minute
- cur_sec  in  6  live second
- year_d  out  15  set year
- month_d  out  4  set month 1..12
- day_d  out  5  set day 1..31
- hour_d  out  6  set hour 0..23
- min_d  out  6  set minute 0..59
- sec_d  out  6  set second 0..59
- week_s  out  4  weekday, 1=Mon..7=Sun
- mode  out  4  0 = load/edit, RUN_MODE = run
- field_sel  out  3  selected field: 0=yr, 1=mon, 2=day, 3=hr, 4=min, 5=sec, 7=none

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: year_d=2023, month_d=5, day_d=9, hour_d=0, min_d=0, sec_d=0, week_s=2, mode=RUN_MODE, field_sel=7, state=RUN.
- States: RUN, EDIT, WAIT_DOW.
- Button priority within one cycle: btn_mode > btn_next > btn_up > btn_down. Lower-priority pulses in the same cycle are ignored.
- RUN:
  - Every cycle, the edit registers (the *_d outputs) load cur_*.
  - week_s holds its last value.
  - mode=RUN_MODE.
  - btn_mode: next cycle -> EDIT, field_sel=0, mode=0. The fields hold the values captured on the btn_mode cycle.
- EDIT:
  - mode=0; all outputs are stable except on button cycles.
  - btn_next: field_sel goes 0->1->...->5->0.
  - btn_up/btn_down: modify the selected field by +/-1 with wrap:
    - year: YEAR_MIN..YEAR_MAX
    - month: 1..12
    - day: 1..dim(month, year)
    - hour: 0..23
    - min, sec: 0..59
  - Leap year: divisible by 4 and (not divisible by 100, or divisible by 400). dim(Feb) = 29 if leap, else 28.
  - A year or month change that leaves day_d > dim clamps day_d to dim in the same update.
  - Any change to year/month/day (including a clamp) issues a start pulse to the dow sub-module. week_s updates when it reports done.
  - btn_mode: -> WAIT_DOW, field_sel=7.
- WAIT_DOW:
  - mode stays 0; all buttons are ignored.
  - A dow start is always issued on entry.
  - When done: week_s is latched; on the next cycle state=RUN and mode=RUN_MODE.
  - Total exit latency: 3 cycles from btn_mode.
  - mode never becomes nonzero while week_s is stale.
- Weekday arithmetic (Zeller):
  - If m <= 2: m += 12 and y -= 1.
  - K = y mod 100, J = y / 100.
  - h = (q + 13(m+1)/5 + K + K/4 + J/4 + 5J) mod 7.
  - week_s = ((h+5) mod 7) + 1.
  - Divisions are by constants; intermediate width is 17 bits unsigned.
- Reset mid-edit: immediate return to reset values; an in-flight dow result is discarded.

Optional Feature:
- Macro: TIME_SETTER_SEC_ZERO_EN.
- Defined: in EDIT with field_sel=5, btn_up or btn_down forces sec_d=0 instead of stepping.
- Undefined: seconds step with wrap like the other fields.

Decomposition:
- Shared package time_pkg holds:
  - field index constants FLD_YEAR..FLD_SEC and FLD_NONE=7;
  - the state enum;
  - reset-date constants;
  - an is_leap function;
  - a days_in_month function.
- Sub-module dow_calc: inputs start, year, month, day; outputs week (4 bits) and done.
  - Two registered stages (adjust/split, then sum/mod 7).
  - done pulses 2 cycles after start.
  - A restart while busy supersedes the pending result.

Test Plan:
- Reset, then cur_*=2023-05-09 12:00:00, then btn_mode, then btn_mode -> mode=0 for 3 cycles, then week_s=2 and mode=1.
- Seed 2000-02-29, enter edit, btn_up on year -> year_d=2001, day_d=28, week_s=3 (Wednesday).
- Year 9999 + btn_up -> 1583; month 12 + btn_up -> 1; sec 0 + btn_down -> 59; hour 23 + btn_up -> 0.
- Seed 2023-01-31, select month, btn_up -> month_d=2, day_d=28; btn_down -> month_d=1, day_d=28 (no un-clamp).
- btn_next and btn_up in the same cycle at field 0 -> field_sel=1, year unchanged; btn_mode+btn_up -> exit, no change.
- rst asserted in WAIT_DOW -> outputs at reset values the same cycle; mode=RUN_MODE, field_sel=7.
